pcnn_result_collector: RTL and testbench
========================================

Name: pcnn_result_collector

Overview:
- Sits downstream of the pcnn convolution engine. Captures the engine's 20-bit result stream and quantises each sample to 8 bits.
- Stores one complete output feature map in row-major order. The host reads the map back through a registered read port.
- This block is the consuming end of the engine's result interface. The engine writes results; this block receives and buffers them.

Parameters:
- a_size, 6, input image edge length (same meaning as in the engine).
- f_size, 3, filter edge length.
- stride, 1, convolution stride.
- zeropadding, 0, zero-padding width on each side.
- shift, 4, arithmetic right-shift applied before saturation.
- signed_out, 0, 0 = unsigned 8-bit result in 0..255; 1 = signed 8-bit result in -128..127.
- Derived constant o_size = (a_size + 2*zeropadding - f_size)/stride + 1. The defaults give o_size=4.
- Derived constant n_out = o_size*o_size. The defaults give n_out=16.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle start of a new capture.
- in_data  in  20  engine result, two's complement.
- in_valid  in  1  in_data is valid this cycle.
- in_done  in  1  engine finished its frame (pulse).
- rd_en  in  1  host read request.
- rd_addr  in  clog2(n_out)  row-major index, row*o_size+col.
- rd_data  out  8  quantised result.
- rd_valid  out  1  rd_data is valid; asserted one cycle after rd_en.
- busy  out  1  FSM is in CAPTURE.
- done  out  1  level; map complete or closed early.
- short_frame  out  1  sticky; in_done arrived before n_out samples.
- overflow  out  1  sticky; in_valid arrived outside CAPTURE, or after n_out samples.
- count  out  clog2(n_out+1)  number of samples stored in the current frame.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, busy=0, done=0, short_frame=0, overflow=0, count=0, FSM=IDLE, written mask all 0.
- The sample store itself is not reset; the written mask gates every read.
- FSM states:
  - IDLE: go -> CAPTURE.
  - CAPTURE:
    - Each in_valid stores the quantised sample at index count, sets written[count] and increments count.
    - When count reaches n_out on a write -> READY with done=1.
    - in_done with count<n_out -> READY with done=1 and short_frame=1.
    - in_valid and in_done in the same cycle: the sample is stored first, then in_done is evaluated against the post-increment count.
  - READY: go -> CAPTURE.
- On go in any state:
  - count, the written mask, done, short_frame and overflow clear on the next edge.
  - An in_valid in the same cycle as go is ignored. Capture starts the cycle after go.
- in_valid outside CAPTURE (IDLE or READY): the sample is dropped and overflow is set. A sample is never written outside CAPTURE.
- busy=1 exactly while in CAPTURE.
- Quantise, applied combinationally before the store write:
  - Step 1: s = in_data >>> shift, arithmetic shift over 20 bits.
  - Step 2, signed_out=0: s<0 -> 0; s>255 -> 255; otherwise s[7:0].
  - Step 2, signed_out=1: s<-128 -> 0x80; s>127 -> 0x7F; otherwise s[7:0].
- Read port:
  - Registered, one-cycle latency, available in every state.
  - rd_valid follows rd_en by one cycle.
  - rd_data = store[rd_addr] if written[rd_addr], otherwise 0.
  - rd_addr >= n_out returns 0.
  - A read and a write to the same index in the same cycle returns the old content, or 0 if the index was unwritten before that cycle.
- The row and col of the last write are derivable from count. No separate row/col counters are exported.
- Reset mid-capture: everything returns to reset values immediately and asynchronously. A partial map is never reported as done.

Decomposition:
- Shared package pcnn_pkg:
  - The o_size/n_out derivation as a function.
  - Collector FSM state encoding: IDLE=2'd0, CAPTURE=2'd1, READY=2'd2.
  - Output width constant 8.
- One sub-module: pcnn_quantize, combinational 20->8 shift-and-saturate with shift and signed_out parameters. It is reusable by other engine outputs.
- Store: plain register array inside the collector.

Test Plan:
- Reset, go, then 16 samples with in_data=k*16 (k=0..15), shift=4, then read all 16 indices.
  - Required: rd_data=k.
  - Required: done=1 on the edge of the 16th write; busy drops on the same edge.
  - Required: short_frame=0, overflow=0.
- Saturation, signed_out=0.
  - in_data=20'hFFFF0 (-16) -> 0.
  - in_data=5000 -> 255.
  - in_data=20'h7FFFF -> 255.
- Saturation, signed_out=1.
  - in_data=-4096 -> 0x80.
  - in_data=-32 -> 0xFE.
  - in_data=2047 -> 0x7F.
- go, 5 samples, in_done pulse on the 5th, then read indices 4 and 5.
  - Required: count=5, done=1, short_frame=1.
  - Required: index 4 holds its sample; index 5 reads 0.
- After done, a 17th in_valid with value 320.
  - Required: overflow=1; all 16 stored values unchanged.
  - Then go: overflow=0, count=0, and every read returns 0.
- Assert reset for 1 cycle after 7 samples.
  - Required: busy=0, done=0, count=0 immediately; reads return 0.
  - Then a new go with 16 samples completes normally.

Source files
------------

// File: rtl/pcnn_pkg.sv
// Shared definitions for the pcnn engine and its result path.
package pcnn_pkg;

  localparam int unsigned in_w  = 20;
  localparam int unsigned out_w = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } coll_state_e;

  function automatic int unsigned calc_o_size(input int unsigned a_size,
                                              input int unsigned f_size,
                                              input int unsigned stride,
                                              input int unsigned zeropadding);
    return (a_size + 2 * zeropadding - f_size) / stride + 1;
  endfunction

  function automatic int unsigned calc_n_out(input int unsigned a_size,
                                             input int unsigned f_size,
                                             input int unsigned stride,
                                             input int unsigned zeropadding);
    int unsigned o;
    o = calc_o_size(a_size, f_size, stride, zeropadding);
    return o * o;
  endfunction

endpackage

// File: rtl/pcnn_quantize.sv
// Combinational 20->8 arithmetic shift and saturate; reusable on any engine output.
module pcnn_quantize
  import pcnn_pkg::*;
#(
  parameter int unsigned shift      = 4,
  parameter int unsigned signed_out = 0
) (
  input  logic [in_w-1:0]  in_data,
  output logic [out_w-1:0] q_c
);

  logic signed [in_w-1:0] s;

  always_comb begin
    s   = $signed(in_data) >>> shift;
    q_c = s[out_w-1:0];
    if (signed_out != 0) begin
      if (s < -20'sd128)     q_c = 8'h80;
      else if (s > 20'sd127) q_c = 8'h7F;
    end else begin
      if (s < 20'sd0)        q_c = 8'h00;
      else if (s > 20'sd255) q_c = 8'hFF;
    end
  end

endmodule

// File: rtl/pcnn_result_collector.sv
// Captures one quantised output feature map from the pcnn engine and serves host reads.
module pcnn_result_collector
  import pcnn_pkg::*;
#(
  parameter int unsigned a_size      = 6,
  parameter int unsigned f_size      = 3,
  parameter int unsigned stride      = 1,
  parameter int unsigned zeropadding = 0,
  parameter int unsigned shift       = 4,
  parameter int unsigned signed_out  = 0,
  localparam int unsigned n_out = calc_n_out(a_size, f_size, stride, zeropadding),
  localparam int unsigned aw    = (n_out > 1) ? $clog2(n_out) : 1,
  localparam int unsigned cw    = $clog2(n_out + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [in_w-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_done,
  input  logic             rd_en,
  input  logic [aw-1:0]    rd_addr,
  output logic [out_w-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             short_frame,
  output logic             overflow,
  output logic [cw-1:0]    count
);

  coll_state_e      state;
  logic [n_out-1:0] written;
  logic [out_w-1:0] store [n_out];
  logic [out_w-1:0] q_c;
  logic             wr_en_c;
  logic             rd_hit_c;
  logic             last_c;

  pcnn_quantize #(
    .shift      (shift),
    .signed_out (signed_out)
  ) u_quant (
    .in_data (in_data),
    .q_c     (q_c)
  );

  // go wins over a same-cycle sample, so capture only begins the cycle after go
  assign wr_en_c  = (state == CAPTURE) && in_valid && !go;
  assign last_c   = (count == cw'(n_out - 1));
  assign rd_hit_c = (32'(rd_addr) < n_out) && written[rd_addr];

  // Sample store carries no reset; the written mask qualifies every read.
  always_ff @(posedge clk) begin
    if (wr_en_c) store[aw'(count)] <= q_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      written     <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      short_frame <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_hit_c ? store[rd_addr] : '0;

      if (go) begin
        state       <= CAPTURE;
        busy        <= 1'b1;
        written     <= '0;
        count       <= '0;
        done        <= 1'b0;
        short_frame <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        case (state)
          CAPTURE: begin
            if (in_valid) begin
              written[aw'(count)] <= 1'b1;
              count               <= count + cw'(1);
            end
            // in_done is judged against the post-write count
            if (in_valid && last_c) begin
              state <= READY;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (in_done) begin
              state       <= READY;
              busy        <= 1'b0;
              done        <= 1'b1;
              short_frame <= 1'b1;
            end
          end
          default: begin
            if (in_valid) overflow <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcnn_result_collector.sv
// Directed bench for pcnn_result_collector: unsigned and signed quantising instances share stimulus.
module tb_pcnn_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [19:0] in_data;
  logic        in_valid;
  logic        in_done;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [7:0]  rd_data,  rd_data_s;
  logic        rd_valid, rd_valid_s;
  logic        busy,     busy_s;
  logic        done,     done_s;
  logic        short_frame, short_frame_s;
  logic        overflow, overflow_s;
  logic [4:0]  count,    count_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pcnn_result_collector dut (
    .clk(clk), .reset(reset), .go(go), .in_data(in_data), .in_valid(in_valid),
    .in_done(in_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .short_frame(short_frame),
    .overflow(overflow), .count(count)
  );

  pcnn_result_collector #(.signed_out(1)) dut_s (
    .clk(clk), .reset(reset), .go(go), .in_data(in_data), .in_valid(in_valid),
    .in_done(in_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .busy(busy_s), .done(done_s), .short_frame(short_frame_s),
    .overflow(overflow_s), .count(count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_go();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic send(input logic [19:0] d, input logic dn);
    in_valid = 1'b1;
    in_data  = d;
    in_done  = dn;
    step();
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic rd(input int addr);
    rd_en   = 1'b1;
    rd_addr = 4'(addr);
    step();
    rd_en   = 1'b0;
  endtask

  logic [19:0] sat_in [6];
  logic [7:0]  sat_u  [6];
  logic [7:0]  sat_s  [6];

  initial begin
    sat_in[0] = 20'hFFFF0;    sat_u[0] = 8'h00; sat_s[0] = 8'hFF;
    sat_in[1] = 20'd5000;     sat_u[1] = 8'hFF; sat_s[1] = 8'h7F;
    sat_in[2] = 20'h7FFFF;    sat_u[2] = 8'hFF; sat_s[2] = 8'h7F;
    sat_in[3] = -20'sd4096;   sat_u[3] = 8'h00; sat_s[3] = 8'h80;
    sat_in[4] = -20'sd32;     sat_u[4] = 8'h00; sat_s[4] = 8'hFE;
    sat_in[5] = 20'd2047;     sat_u[5] = 8'h7F; sat_s[5] = 8'h7F;

    reset = 1'b1; go = 1'b0; in_data = '0; in_valid = 1'b0; in_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_rdv", 32'(rd_valid), 0);
    rd(0);
    check("rst_read0", 32'(rd_data), 0);

    // full frame, in_data = k*16 quantises to k
    do_go();
    check("go_busy", 32'(busy), 1);
    for (int k = 0; k < 16; k++) begin
      send(20'(k * 16), 1'b0);
      if (k == 14) begin
        check("pre_last_done", 32'(done), 0);
        check("pre_last_busy", 32'(busy), 1);
      end
    end
    check("full_done", 32'(done), 1);
    check("full_busy", 32'(busy), 0);
    check("full_count", 32'(count), 16);
    check("full_short", 32'(short_frame), 0);
    check("full_ovf", 32'(overflow), 0);
    check("full_done_s", 32'(done_s), 1);
    for (int k = 0; k < 16; k++) begin
      rd(k);
      check("full_rd", 32'(rd_data), 32'(k));
      check("full_rdv", 32'(rd_valid), 1);
    end
    step();
    check("rdv_drop", 32'(rd_valid), 0);

    // extra sample after the map is complete
    send(20'd320, 1'b0);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    for (int k = 0; k < 16; k++) begin
      rd(k);
      check("ovf_keep", 32'(rd_data), 32'(k));
    end

    // go clears everything, sample alongside go is ignored
    go = 1'b1; in_valid = 1'b1; in_data = 20'd80;
    step();
    go = 1'b0; in_valid = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_count", 32'(count), 0);
    check("clr_done", 32'(done), 0);
    for (int k = 0; k < 16; k++) begin
      rd(k);
      check("clr_rd", 32'(rd_data), 0);
    end

    // saturation on both instances
    for (int k = 0; k < 6; k++) send(sat_in[k], 1'b0);
    send(20'd0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      rd(k);
      check("sat_u", 32'(rd_data), 32'(sat_u[k]));
      check("sat_s", 32'(rd_data_s), 32'(sat_s[k]));
    end

    // short frame: in_done with the fifth sample
    do_go();
    for (int k = 0; k < 5; k++) send(20'((k + 10) * 16), k == 4);
    check("short_count", 32'(count), 5);
    check("short_done", 32'(done), 1);
    check("short_flag", 32'(short_frame), 1);
    check("short_busy", 32'(busy), 0);
    rd(4);
    check("short_rd4", 32'(rd_data), 14);
    rd(5);
    check("short_rd5", 32'(rd_data), 0);

    // read and write to the same unwritten index in one cycle returns 0
    do_go();
    rd_en = 1'b1; rd_addr = 4'd0;
    send(20'd48, 1'b0);
    rd_en = 1'b0;
    check("rw_same", 32'(rd_data), 0);
    rd(0);
    check("rw_after", 32'(rd_data), 3);

    // asynchronous reset mid-capture
    for (int k = 1; k < 7; k++) send(20'(k * 16), 1'b0);
    check("pre_rst_count", 32'(count), 7);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_count", 32'(count), 0);
    step();
    reset = 1'b0;
    rd(0);
    check("arst_rd0", 32'(rd_data), 0);
    rd(6);
    check("arst_rd6", 32'(rd_data), 0);

    // recovery frame, values 16+k
    do_go();
    for (int k = 0; k < 16; k++) send(20'((k + 16) * 16), 1'b0);
    check("rec_done", 32'(done), 1);
    check("rec_short", 32'(short_frame), 0);
    check("rec_ovf", 32'(overflow), 0);
    rd(0);
    check("rec_rd0", 32'(rd_data), 16);
    rd(15);
    check("rec_rd15", 32'(rd_data), 31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
